// File: rtl/mem_access_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_access_unit_pkg
// Description : Shared bus/access definitions for the memory access unit:
//               FSM state encoding, MEM_SEL size codes and lane helpers.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_access_unit_pkg;

  // Bus geometry
  localparam int unsigned BUS_DATA_W  = 32;
  localparam int unsigned BUS_ADDR_W  = 32;
  localparam int unsigned BUS_STRB_W  = BUS_DATA_W / 8;

  // Access size codes carried on mem_sel
  localparam logic [3:0] SEL_BYTE = 4'b0001;
  localparam logic [3:0] SEL_HALF = 4'b0011;
  localparam logic [3:0] SEL_WORD = 4'b1111;

  // Access FSM state encoding
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // True for the three legal access sizes
  function automatic logic sel_valid(input logic [3:0] sel);
    return (sel == SEL_BYTE) || (sel == SEL_HALF) || (sel == SEL_WORD);
  endfunction

  // Natural alignment check: halves on even bytes, words on word boundaries
  function automatic logic sel_aligned(input logic [3:0] sel, input logic [1:0] lo);
    logic ok;
    case (sel)
      SEL_HALF: ok = ~lo[0];
      SEL_WORD: ok = (lo == 2'b00);
      default:  ok = 1'b1;
    endcase
    return ok;
  endfunction

  // Little-endian byte-lane strobes for a store
  function automatic logic [3:0] lane_strobe(input logic [3:0] sel, input logic [1:0] lo);
    logic [3:0] s;
    case (sel)
      SEL_BYTE: s = 4'b0001 << lo;
      SEL_HALF: s = 4'b0011 << {lo[1], 1'b0};
      SEL_WORD: s = 4'b1111;
      default:  s = 4'b0000;
    endcase
    return s;
  endfunction

  // Replicate right-justified store data across all lanes it may land on
  function automatic logic [31:0] lane_replicate(input logic [3:0] sel, input logic [31:0] d);
    logic [31:0] r;
    case (sel)
      SEL_BYTE: r = {4{d[7:0]}};
      SEL_HALF: r = {2{d[15:0]}};
      default:  r = d;
    endcase
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_access_unit_load_align.sv
`default_nettype none
// ============================================================================
// Module      : load_align
// Description : Combinational load extraction: picks the addressed byte or
//               half out of a bus word and sign- or zero-extends it.
// Revision    : 1.0 - initial release
// ============================================================================
module load_align
  import mem_access_unit_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [1:0]  addr_i,
  input  logic [3:0]  sel_i,
  input  logic        ext_i,
  output logic [31:0] result_o
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // Lane selection and extension
  always_comb begin
    w_byte   = 8'h00;
    w_half   = 16'h0000;
    result_o = 32'h0000_0000;
    case (addr_i)
      2'd0:    w_byte = word_i[7:0];
      2'd1:    w_byte = word_i[15:8];
      2'd2:    w_byte = word_i[23:16];
      default: w_byte = word_i[31:24];
    endcase
    w_half = addr_i[1] ? word_i[31:16] : word_i[15:0];
    case (sel_i)
      SEL_BYTE: result_o = {{24{ext_i & w_byte[7]}}, w_byte};
      SEL_HALF: result_o = {{16{ext_i & w_half[15]}}, w_half};
      SEL_WORD: result_o = word_i;
      default:  result_o = 32'h0000_0000;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module      : mem_access_unit
// Description : Load/store unit between the ID/EX stage and a single-beat
//               ready-handshake RAM bus. Three-state access FSM with
//               registered bus outputs, stall generation and load alignment.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_access_unit
  import mem_access_unit_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        mem_read_flag_i,
  input  logic        mem_write_flag_i,
  input  logic        mem_sign_ext_flag_i,
  input  logic [3:0]  mem_sel_i,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] mem_write_data_i,
  input  logic        flush_i,
  output logic        ram_en_o,
  output logic [3:0]  ram_write_en_o,
  output logic [31:0] ram_addr_o,
  output logic [31:0] ram_write_data_o,
  input  logic [31:0] ram_read_data_i,
  input  logic        ram_ready_i,
  output logic        stall_request_o,
  output logic [31:0] load_data_o,
  output logic        load_valid_o,
  output logic        addr_error_o
);

  state_e      state_q, state_d;
  logic        ram_en_q, ram_en_d;
  logic [3:0]  ram_we_q, ram_we_d;
  logic [31:0] ram_addr_q, ram_addr_d;
  logic [31:0] ram_wdata_q, ram_wdata_d;
  logic [3:0]  sel_q, sel_d;
  logic [1:0]  addr_lo_q, addr_lo_d;
  logic        ext_q, ext_d;
  logic        is_load_q, is_load_d;
  logic        flushed_q, flushed_d;
  logic [31:0] load_data_q, load_data_d;
  logic        load_valid_q, load_valid_d;

  logic        w_access;
  logic        w_sel_ok;
  logic        w_aligned;
  logic        w_request;
  logic [31:0] w_aligned_data;

  assign w_access  = mem_read_flag_i | mem_write_flag_i;
  assign w_sel_ok  = sel_valid(mem_sel_i);
  assign w_aligned = sel_aligned(mem_sel_i, mem_addr_i[1:0]);
  assign w_request = (state_q == ST_IDLE) & w_access & w_sel_ok & ~flush_i & w_aligned;

  // Pipeline-side indications are combinational so the stall lands this cycle
  assign stall_request_o = w_request | (state_q == ST_BUSY);
  assign addr_error_o    = (state_q == ST_IDLE) & w_access & w_sel_ok & ~w_aligned;

  assign ram_en_o         = ram_en_q;
  assign ram_write_en_o   = ram_we_q;
  assign ram_addr_o       = ram_addr_q;
  assign ram_write_data_o = ram_wdata_q;
  assign load_data_o      = load_data_q;
  assign load_valid_o     = load_valid_q;

  // Aligns the live bus word using the sizes latched at request time
  load_align u_load_align (
    .word_i   (ram_read_data_i),
    .addr_i   (addr_lo_q),
    .sel_i    (sel_q),
    .ext_i    (ext_q),
    .result_o (w_aligned_data)
  );

  // Next-state and registered-output logic for the access FSM
  always_comb begin
    state_d      = state_q;
    ram_en_d     = ram_en_q;
    ram_we_d     = ram_we_q;
    ram_addr_d   = ram_addr_q;
    ram_wdata_d  = ram_wdata_q;
    sel_d        = sel_q;
    addr_lo_d    = addr_lo_q;
    ext_d        = ext_q;
    is_load_d    = is_load_q;
    flushed_d    = flushed_q;
    load_data_d  = load_data_q;
    load_valid_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (w_request) begin
          state_d     = ST_BUSY;
          ram_en_d    = 1'b1;
          is_load_d   = ~mem_write_flag_i;
          ram_we_d    = mem_write_flag_i ? lane_strobe(mem_sel_i, mem_addr_i[1:0]) : 4'b0000;
          ram_addr_d  = {mem_addr_i[31:2], 2'b00};
          ram_wdata_d = lane_replicate(mem_sel_i, mem_write_data_i);
          sel_d       = mem_sel_i;
          addr_lo_d   = mem_addr_i[1:0];
          ext_d       = mem_sign_ext_flag_i;
          flushed_d   = 1'b0;
        end
      end
      ST_BUSY: begin
        // A flush here only marks the result; the bus handshake must finish
        if (flush_i) begin
          flushed_d = 1'b1;
        end
        if (ram_ready_i) begin
          state_d      = ST_DONE;
          ram_en_d     = 1'b0;
          ram_we_d     = 4'b0000;
          if (is_load_q) begin
            load_data_d = w_aligned_data;
          end
          load_valid_d = is_load_q & ~flushed_q & ~flush_i;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d  = ST_IDLE;
        ram_en_d = 1'b0;
        ram_we_d = 4'b0000;
      end
    endcase
  end

  // State and datapath registers, cleared asynchronously
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q      <= ST_IDLE;
      ram_en_q     <= 1'b0;
      ram_we_q     <= 4'b0000;
      ram_addr_q   <= 32'h0000_0000;
      ram_wdata_q  <= 32'h0000_0000;
      sel_q        <= 4'b0000;
      addr_lo_q    <= 2'b00;
      ext_q        <= 1'b0;
      is_load_q    <= 1'b0;
      flushed_q    <= 1'b0;
      load_data_q  <= 32'h0000_0000;
      load_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      ram_en_q     <= ram_en_d;
      ram_we_q     <= ram_we_d;
      ram_addr_q   <= ram_addr_d;
      ram_wdata_q  <= ram_wdata_d;
      sel_q        <= sel_d;
      addr_lo_q    <= addr_lo_d;
      ext_q        <= ext_d;
      is_load_q    <= is_load_d;
      flushed_q    <= flushed_d;
      load_data_q  <= load_data_d;
      load_valid_q <= load_valid_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_access_unit
// Description : Directed self-checking bench for mem_access_unit.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_access_unit;

  logic        clk;
  logic        rst_n;
  logic        rd, wr, ext, flush, ready;
  logic [3:0]  sel;
  logic [31:0] addr, wdata, rdata;
  logic        ram_en, stall, lvalid, aerr;
  logic [3:0]  ram_we;
  logic [31:0] ram_addr, ram_wdata, ldata;

  int passed = 0;
  int total  = 0;

  mem_access_unit dut (
    .clk_i               (clk),
    .rst_n_i             (rst_n),
    .mem_read_flag_i     (rd),
    .mem_write_flag_i    (wr),
    .mem_sign_ext_flag_i (ext),
    .mem_sel_i           (sel),
    .mem_addr_i          (addr),
    .mem_write_data_i    (wdata),
    .flush_i             (flush),
    .ram_en_o            (ram_en),
    .ram_write_en_o      (ram_we),
    .ram_addr_o          (ram_addr),
    .ram_write_data_o    (ram_wdata),
    .ram_read_data_i     (rdata),
    .ram_ready_i         (ready),
    .stall_request_o     (stall),
    .load_data_o         (ldata),
    .load_valid_o        (lvalid),
    .addr_error_o        (aerr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    rd = 1'b0; wr = 1'b0; ext = 1'b0; flush = 1'b0; ready = 1'b0;
    sel = 4'b0000; addr = 32'h0; wdata = 32'h0; rdata = 32'h0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    #12;
    total++; if (ram_en !== 1'b0) $display("FAIL reset_ram_en: got %b want 0", ram_en); else passed++;
    total++; if (ram_we !== 4'b0000) $display("FAIL reset_ram_we: got %b want 0000", ram_we); else passed++;
    total++; if (ram_addr !== 32'h0) $display("FAIL reset_ram_addr: got %h want 0", ram_addr); else passed++;
    total++; if (ram_wdata !== 32'h0) $display("FAIL reset_ram_wdata: got %h want 0", ram_wdata); else passed++;
    total++; if (ldata !== 32'h0 || lvalid !== 1'b0) $display("FAIL reset_load: got %h/%b want 0/0", ldata, lvalid); else passed++;
    total++; if (stall !== 1'b0) $display("FAIL reset_stall: got %b want 0", stall); else passed++;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_lb();
    // LB then LBU of byte 3 holding 0x80
    for (int k = 0; k < 2; k++) begin
      rd = 1'b1; sel = 4'b0001; addr = 32'h0000_1003; ext = (k == 0);
      #1;
      total++; if (stall !== 1'b1) $display("FAIL lb_req_stall: got %b want 1", stall); else passed++;
      tick();
      idle_inputs();
      total++; if (ram_en !== 1'b1 || ram_addr !== 32'h0000_1000 || ram_we !== 4'b0000)
        $display("FAIL lb_busy_bus: got en=%b addr=%h we=%b want 1/00001000/0000", ram_en, ram_addr, ram_we);
      else passed++;
      ready = 1'b1; rdata = 32'h80FF_FFFF;
      tick();
      ready = 1'b0;
      total++; if (lvalid !== 1'b1 || ldata !== ((k == 0) ? 32'hFFFF_FF80 : 32'h0000_0080))
        $display("FAIL lb_result_%0d: got %h/%b want %h/1", k, ldata, lvalid, (k == 0) ? 32'hFFFF_FF80 : 32'h0000_0080);
      else passed++;
      total++; if (stall !== 1'b0 || ram_en !== 1'b0) $display("FAIL lb_done: got stall=%b en=%b want 0/0", stall, ram_en); else passed++;
      tick();
      total++; if (lvalid !== 1'b0) $display("FAIL lb_pulse_width: got %b want 0", lvalid); else passed++;
    end
  endtask

  task automatic test_lh();
    rd = 1'b1; sel = 4'b0011; addr = 32'h0000_0102; ext = 1'b1;
    tick();
    idle_inputs();
    ready = 1'b1; rdata = 32'h8001_1234;
    tick();
    ready = 1'b0;
    total++; if (lvalid !== 1'b1 || ldata !== 32'hFFFF_8001) $display("FAIL lh_result: got %h/%b want ffff8001/1", ldata, lvalid); else passed++;
    tick();
  endtask

  task automatic test_stores();
    // SH to upper half
    wr = 1'b1; sel = 4'b0011; addr = 32'h0000_2002; wdata = 32'h0000_BEEF;
    tick();
    idle_inputs();
    total++; if (ram_we !== 4'b1100) $display("FAIL sh_strobe: got %b want 1100", ram_we); else passed++;
    total++; if (ram_wdata !== 32'hBEEF_BEEF) $display("FAIL sh_data: got %h want beefbeef", ram_wdata); else passed++;
    total++; if (ram_addr !== 32'h0000_2000 || ram_en !== 1'b1) $display("FAIL sh_addr: got %h/%b want 00002000/1", ram_addr, ram_en); else passed++;
    ready = 1'b1;
    tick();
    ready = 1'b0;
    total++; if (lvalid !== 1'b0) $display("FAIL sh_no_valid: got %b want 0", lvalid); else passed++;
    tick();
    // SB to lane 1
    wr = 1'b1; sel = 4'b0001; addr = 32'h0000_0001; wdata = 32'h1234_56A5;
    tick();
    idle_inputs();
    total++; if (ram_we !== 4'b0010 || ram_wdata !== 32'hA5A5_A5A5)
      $display("FAIL sb_lane: got %b/%h want 0010/a5a5a5a5", ram_we, ram_wdata);
    else passed++;
    ready = 1'b1;
    tick();
    ready = 1'b0;
    tick();
  endtask

  task automatic test_lw_delayed();
    int cnt;
    cnt = 0;
    rd = 1'b1; sel = 4'b1111; addr = 32'h0000_4000;
    #1;
    if (stall === 1'b1) cnt++;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (i == 0) idle_inputs();
      total++; if (ram_en !== 1'b1 || ram_addr !== 32'h0000_4000)
        $display("FAIL lw_stable_%0d: got en=%b addr=%h want 1/00004000", i, ram_en, ram_addr);
      else passed++;
      if (stall === 1'b1) cnt++;
      if (i == 3) begin
        ready = 1'b1; rdata = 32'hDEAD_BEEF;
      end
    end
    tick();
    ready = 1'b0;
    total++; if (cnt != 5) $display("FAIL lw_stall_cycles: got %0d want 5", cnt); else passed++;
    total++; if (stall !== 1'b0 || lvalid !== 1'b1 || ldata !== 32'hDEAD_BEEF)
      $display("FAIL lw_done: got stall=%b valid=%b data=%h want 0/1/deadbeef", stall, lvalid, ldata);
    else passed++;
    tick();
  endtask

  task automatic test_misaligned();
    rd = 1'b1; sel = 4'b0011; addr = 32'h0000_3001;
    #1;
    total++; if (aerr !== 1'b1 || stall !== 1'b0) $display("FAIL lh_misaligned: got err=%b stall=%b want 1/0", aerr, stall); else passed++;
    tick();
    total++; if (ram_en !== 1'b0) $display("FAIL lh_misaligned_bus: got %b want 0", ram_en); else passed++;
    sel = 4'b1111; addr = 32'h0000_3002;
    #1;
    total++; if (aerr !== 1'b1) $display("FAIL lw_misaligned: got %b want 1", aerr); else passed++;
    sel = 4'b1111; addr = 32'h0000_3000;
    #1;
    total++; if (aerr !== 1'b0) $display("FAIL lw_aligned_err: got %b want 0", aerr); else passed++;
    idle_inputs();
    tick();
  endtask

  task automatic test_flush();
    // Flush in IDLE suppresses the request
    rd = 1'b1; sel = 4'b1111; addr = 32'h0000_5000; flush = 1'b1;
    #1;
    total++; if (stall !== 1'b0) $display("FAIL flush_idle_stall: got %b want 0", stall); else passed++;
    tick();
    total++; if (ram_en !== 1'b0) $display("FAIL flush_idle_bus: got %b want 0", ram_en); else passed++;
    // Flush in BUSY keeps the handshake but drops the result
    flush = 1'b0;
    tick();
    idle_inputs();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    total++; if (ram_en !== 1'b1) $display("FAIL flush_busy_hold: got %b want 1", ram_en); else passed++;
    ready = 1'b1; rdata = 32'h1111_2222;
    tick();
    ready = 1'b0;
    total++; if (lvalid !== 1'b0 || ram_en !== 1'b0) $display("FAIL flush_busy_valid: got valid=%b en=%b want 0/0", lvalid, ram_en); else passed++;
    tick();
  endtask

  task automatic test_reset_mid_busy();
    rd = 1'b1; sel = 4'b1111; addr = 32'h0000_7004;
    tick();
    idle_inputs();
    total++; if (ram_en !== 1'b1) $display("FAIL rst_busy_pre: got %b want 1", ram_en); else passed++;
    #2;
    rst_n = 1'b0;
    #1;
    total++; if (ram_en !== 1'b0 || ram_addr !== 32'h0) $display("FAIL rst_async: got en=%b addr=%h want 0/0", ram_en, ram_addr); else passed++;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    total++; if (stall !== 1'b0 || ram_en !== 1'b0) $display("FAIL rst_idle: got stall=%b en=%b want 0/0", stall, ram_en); else passed++;
  endtask

  task automatic test_back_to_back();
    rd = 1'b1; sel = 4'b1111; addr = 32'h0000_6000; ready = 1'b1; rdata = 32'hCAFE_F00D;
    tick();
    total++; if (ram_en !== 1'b1) $display("FAIL b2b_busy1: got %b want 1", ram_en); else passed++;
    tick();
    total++; if (lvalid !== 1'b1 || stall !== 1'b0) $display("FAIL b2b_done1: got valid=%b stall=%b want 1/0", lvalid, stall); else passed++;
    tick();
    total++; if (ram_en !== 1'b0 || stall !== 1'b1) $display("FAIL b2b_idle2: got en=%b stall=%b want 0/1", ram_en, stall); else passed++;
    tick();
    total++; if (ram_en !== 1'b1) $display("FAIL b2b_busy2: got %b want 1", ram_en); else passed++;
    idle_inputs();
    ready = 1'b1;
    tick();
    ready = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_lb();
    test_lh();
    test_stores();
    test_lw_delayed();
    test_misaligned();
    test_flush();
    test_reset_mid_busy();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 SHALL have a single clock and an asynchronous, active-low reset.
REQ-002 clk  in  1  system clock; all state changes on its rising edge.
REQ-003 rst  in  1  asynchronous active-low reset.
REQ-004 mem_read_flag  in  1  load request from ID/EX pipeline.
REQ-005 mem_write_flag  in  1  store request.
REQ-006 mem_sign_ext_flag  in  1  load result sign-extended when 1, zero-extended when 0; ignored for stores.
REQ-007 mem_sel  in  4  access size: 0001 byte, 0011 half, 1111 word; other values mean no access.
REQ-008 mem_addr  in  32  byte address of the access.
REQ-009 mem_write_data  in  32  store source register, right-justified.
REQ-010 flush  in  1  discard the current/pending access result.
REQ-011 ram_en  out  1  bus request, held until accepted.
REQ-012 ram_write_en  out  4  byte-lane write strobes; 0000 for loads.
REQ-013 ram_addr  out  32  word address {mem_addr[31:2],2'b00}.
REQ-014 ram_write_data  out  32  lane-replicated store data.
REQ-015 ram_read_data  in  32  bus read data, valid when ram_ready=1.
REQ-016 ram_ready  in  1  bus completion for the current request.
REQ-017 stall_request  out  1  freeze the pipeline while 1.
REQ-018 load_data  out  32  aligned, extended load result.
REQ-019 load_valid  out  1  one-cycle pulse with load_data.
REQ-020 addr_error  out  1  misaligned access indication (combinational).

Function
REQ-021 States: IDLE, BUSY, DONE; the state register and all bus-side outputs are registered.
REQ-022 IDLE: request = (read or write) and mem_sel valid and not flush and aligned; on request, latch addr/size/ext/type/strobes/data and go BUSY.
REQ-023 stall_request = request in IDLE, or state==BUSY; it is 0 in DONE.
REQ-024 BUSY: ram_en=1 with latched values stable; on ram_ready=1, capture ram_read_data and go DONE; ram_ready in IDLE/DONE is ignored.
REQ-025 DONE: load_valid=1 for exactly one cycle if the access was a load and was not flushed; unconditionally return to IDLE, with no new request accepted this cycle.
REQ-026 Byte lanes, little-endian: byte strobe = 0001<<addr[1:0]; half strobe = 0011<<{addr[1],1'b0}; word strobe = 1111.
REQ-027 Store data: byte replicated x4, half replicated x2, word as-is.
REQ-028 Load: select the byte or half by latched addr[1:0], then sign- or zero-extend to 32 bits; a word load passes through.
REQ-029 Alignment: half needs addr[0]=0 and word needs addr[1:0]=00; a violation in IDLE raises addr_error, issues no bus access, and does not stall.
REQ-030 flush in IDLE: suppress the request. flush in BUSY: complete the bus handshake (never drop ram_en early) and suppress load_valid.
REQ-031 Back-to-back accesses: minimum 3 cycles each (IDLE, BUSY, DONE) with ram_ready=1 on the first BUSY cycle.

Reset
REQ-032 While rst=0: state=IDLE; ram_en=0, ram_write_en=0000, ram_addr=0, ram_write_data=0, load_data=0, load_valid=0, all latches cleared; asserts immediately (asynchronously).
REQ-033 Reset mid-BUSY abandons the transaction; the bus must tolerate ram_en dropping.

Structure
REQ-034 State encoding and MEM_SEL size constants SHALL live in the shared include/package beside the existing bus/opcode definitions.
REQ-035 Load extraction/extension SHALL be a combinational sub-module load_align (inputs: word, addr[1:0], sel, ext; output: 32-bit result).

Verification
REQ-036 LB addr 0x1003, ram_read_data 0x80FFFFFF, ext=1 -> load_data 0xFFFFFF80; with ext=0 (LBU) -> 0x00000080.
REQ-037 SH addr 0x2002, data 0x0000BEEF -> ram_write_en 1100, ram_write_data 0xBEEFBEEF, ram_addr 0x2000.
REQ-038 LW with ram_ready delayed 4 cycles -> stall_request high for 5 cycles, ram_en and ram_addr stable, load_valid pulse in DONE.
REQ-039 LH addr 0x3001 -> addr_error=1, ram_en stays 0, stall_request=0.
REQ-040 flush during BUSY of an LW -> handshake completes, load_valid stays 0; rst pulsed mid-BUSY -> ram_en 0 immediately, state IDLE.
